// File: rtl/div_unit.sv
// Iterative radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU with a short path for special cases.
// Optional DIV_EARLY_TERM_EN: skip iteration when |dividend| < |divisor|.
module div_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            valid_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] result_o,
  output logic            ready_o,
  output logic            busy_o
);

  localparam int unsigned CntW = $clog2(XLEN) + 1;
  localparam logic [XLEN-1:0] MinInt = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StCalc, StEnd} state_e;

  state_e          state_q;
  logic [1:0]      op_q;
  logic            dvd_neg_q, dvs_neg_q, skip_q;
  logic [XLEN-1:0] dvs_q, quo_q, result_q;
  logic [XLEN:0]   rem_q;
  logic [CntW-1:0] count_q;
  logic            ready_q;

  logic            is_signed, dvd_neg, dvs_neg, ovf;
  logic [XLEN-1:0] mag_dvd, mag_dvs, quo_fix, rem_fix;
  logic [XLEN:0]   rem_shift, diff;

  always_comb begin
    is_signed = ~op_i[0];
    dvd_neg   = is_signed & dividend_i[XLEN-1];
    dvs_neg   = is_signed & divisor_i[XLEN-1];
    mag_dvd   = dvd_neg ? -dividend_i : dividend_i;
    mag_dvs   = dvs_neg ? -divisor_i : divisor_i;
    ovf       = is_signed && (dividend_i == MinInt) && (divisor_i == '1);
    // quo_q doubles as the dividend shift register: dividend bits leave at the MSB while
    // quotient bits enter at the LSB.
    rem_shift = {rem_q[XLEN-1:0], quo_q[XLEN-1]};
    diff      = rem_shift - {1'b0, dvs_q};
    quo_fix   = (!skip_q && op_q[0] == 1'b0 && (dvd_neg_q ^ dvs_neg_q)) ? -quo_q : quo_q;
    rem_fix   = (!skip_q && op_q[0] == 1'b0 && dvd_neg_q) ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= StIdle;
      op_q      <= '0;
      dvd_neg_q <= 1'b0;
      dvs_neg_q <= 1'b0;
      skip_q    <= 1'b0;
      dvs_q     <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      count_q   <= '0;
      result_q  <= '0;
      ready_q   <= 1'b0;
    end else if (!valid_i) begin
      state_q   <= StIdle;
      op_q      <= '0;
      dvd_neg_q <= 1'b0;
      dvs_neg_q <= 1'b0;
      skip_q    <= 1'b0;
      dvs_q     <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      count_q   <= '0;
      result_q  <= '0;
      ready_q   <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          ready_q   <= 1'b0;
          op_q      <= op_i[1:0];
          dvd_neg_q <= dvd_neg;
          dvs_neg_q <= dvs_neg;
          dvs_q     <= mag_dvs;
          quo_q     <= mag_dvd;
          rem_q     <= '0;
          count_q   <= CntW'(XLEN);
          skip_q    <= 1'b0;
          state_q   <= StCalc;
          // Special results are preloaded into quo_q/rem_q and bypass the sign fix.
          if (!op_i[2]) begin
            quo_q   <= '0;
            skip_q  <= 1'b1;
            state_q <= StEnd;
          end else if (divisor_i == '0) begin
            quo_q   <= '1;
            rem_q   <= {1'b0, dividend_i};
            skip_q  <= 1'b1;
            state_q <= StEnd;
          end else if (ovf) begin
            quo_q   <= MinInt;
            skip_q  <= 1'b1;
            state_q <= StEnd;
          end
`ifdef DIV_EARLY_TERM_EN
          else if (mag_dvd < mag_dvs) begin
            quo_q   <= '0;
            rem_q   <= {1'b0, dividend_i};
            skip_q  <= 1'b1;
            state_q <= StEnd;
          end
`endif
        end
        StCalc: begin
          if (!diff[XLEN]) begin
            rem_q <= diff;
            quo_q <= {quo_q[XLEN-2:0], 1'b1};
          end else begin
            rem_q <= rem_shift;
            quo_q <= {quo_q[XLEN-2:0], 1'b0};
          end
          count_q <= count_q - 1'b1;
          if (count_q == CntW'(1)) state_q <= StEnd;
        end
        StEnd: begin
          result_q <= op_q[1] ? rem_fix : quo_fix;
          ready_q  <= 1'b1;
          state_q  <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;
  assign busy_o   = (state_q != StIdle);

endmodule

// File: tb/tb_div_unit.sv
// Self-checking bench for div_unit: directed vector table plus abort and reset sequences.
module tb_div_unit;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        valid_i = 1'b0;
  logic [2:0]  op_i = 3'b000;
  logic [31:0] dividend_i = '0;
  logic [31:0] divisor_i = '0;
  logic [31:0] result_o;
  logic        ready_o;
  logic        busy_o;

  int checks = 0;
  int errors = 0;

  localparam logic [2:0] OpDiv = 3'b100, OpDivu = 3'b101, OpRem = 3'b110, OpRemu = 3'b111;
`ifdef DIV_EARLY_TERM_EN
  localparam int EarlyLat = 2;
`else
  localparam int EarlyLat = 34;
`endif

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  div_unit #(.XLEN(32)) dut (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .valid_i    (valid_i),
    .op_i       (op_i),
    .dividend_i (dividend_i),
    .divisor_i  (divisor_i),
    .result_o   (result_o),
    .ready_o    (ready_o),
    .busy_o     (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got 0x%08h, expected 0x%08h", name, idx, act, exp);
    end
  endtask

  task automatic run_op(input int idx, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat);
    int edges;
    bit got;
    @(negedge clk_i);
    valid_i = 1'b1;
    op_i = op;
    dividend_i = a;
    divisor_i = b;
    edges = 0;
    got = 1'b0;
    while (edges < 100 && !got) begin
      @(posedge clk_i);
      #1;
      edges++;
      if (edges == 1) check("busy_after_start", idx, {31'd0, busy_o}, 32'd1);
      if (ready_o) got = 1'b1;
    end
    check("ready_seen", idx, {31'd0, got}, 32'd1);
    check("result", idx, result_o, exp);
    check("latency", idx, edges, lat);
    @(negedge clk_i);
    valid_i = 1'b0;
    @(posedge clk_i);
    #1;
    check("ready_pulse", idx, {31'd0, ready_o}, 32'd0);
  endtask

  initial begin
    vec_t vecs[16];
    vecs[0]  = '{OpDivu, 32'd100,        32'd7,          32'd14,         34};
    vecs[1]  = '{OpRemu, 32'd100,        32'd7,          32'd2,          34};
    vecs[2]  = '{OpDivu, 32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   34};
    vecs[3]  = '{OpDiv,  -32'sd7,        32'd2,          32'hFFFFFFFD,   34};
    vecs[4]  = '{OpRem,  -32'sd7,        32'd2,          32'hFFFFFFFF,   34};
    vecs[5]  = '{OpRem,  32'd7,          -32'sd2,        32'd1,          34};
    vecs[6]  = '{OpDiv,  -32'sd8,        -32'sd2,        32'd4,          34};
    vecs[7]  = '{OpDiv,  32'h80000000,   32'd0,          32'hFFFFFFFF,   2};
    vecs[8]  = '{OpRemu, 32'd5,          32'd0,          32'd5,          2};
    vecs[9]  = '{OpRem,  -32'sd5,        32'd0,          32'hFFFFFFFB,   2};
    vecs[10] = '{OpDiv,  32'h80000000,   32'hFFFFFFFF,   32'h80000000,   2};
    vecs[11] = '{OpRem,  32'h80000000,   32'hFFFFFFFF,   32'd0,          2};
    vecs[12] = '{OpDivu, 32'd3,          32'd10,         32'd0,          EarlyLat};
    vecs[13] = '{OpRemu, 32'd3,          32'd10,         32'd3,          EarlyLat};
    vecs[14] = '{OpDiv,  32'h80000000,   32'd3,          32'hD5555556,   34};
    vecs[15] = '{3'b010, 32'd100,        32'd7,          32'd0,          2};

    #2;
    check("reset_result", 0, result_o, 32'd0);
    check("reset_ready", 0, {31'd0, ready_o}, 32'd0);
    check("reset_busy", 0, {31'd0, busy_o}, 32'd0);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;

    for (int i = 0; i < 16; i++) begin
      run_op(i, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat);
    end

    // Abort after 10 iterations, then restart cleanly.
    @(negedge clk_i);
    valid_i = 1'b1;
    op_i = OpDivu;
    dividend_i = 32'd100;
    divisor_i = 32'd7;
    repeat (11) @(posedge clk_i);
    #1;
    check("abort_busy_before", 100, {31'd0, busy_o}, 32'd1);
    @(negedge clk_i);
    valid_i = 1'b0;
    @(posedge clk_i);
    #1;
    check("abort_ready", 100, {31'd0, ready_o}, 32'd0);
    check("abort_idle", 100, {31'd0, busy_o}, 32'd0);
    check("abort_result", 100, result_o, 32'd0);
    run_op(101, OpDivu, 32'd9, 32'd3, 32'd3, 34);

    // Asynchronous reset mid-CALC.
    @(negedge clk_i);
    valid_i = 1'b1;
    op_i = OpDivu;
    dividend_i = 32'd1000;
    divisor_i = 32'd3;
    repeat (6) @(posedge clk_i);
    #2;
    check("rst_busy_before", 200, {31'd0, busy_o}, 32'd1);
    rst_ni = 1'b0;
    #1;
    check("rst_result", 200, result_o, 32'd0);
    check("rst_ready", 200, {31'd0, ready_o}, 32'd0);
    check("rst_busy", 200, {31'd0, busy_o}, 32'd0);
    @(negedge clk_i);
    valid_i = 1'b0;
    rst_ni = 1'b1;
    run_op(201, OpRemu, 32'd1000, 32'd3, 32'd1, 34);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
